de_mem_responder: RTL and testbench
===================================

# de_mem_responder

Memory-side responder for the drawing-engine `de_*` request interface. It accepts one request at a time from a drawing function, such as a rectangle or line engine, and performs it on a synchronous 32-bit frame-store SRAM port. Writes are posted through a single-entry write buffer. Reads stall the requester until data returns. It sits between the drawing function and the frame-store RAM.

## Interface
- `WAIT_STATES`, default 1: extra SRAM cycles per access, legal range 0..7.
- `clk` input 1: system clock; all state changes on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `de_req` input 1: request from the drawing function; held high with stable fields until `de_ack`.
- `de_ack` output 1: one-cycle acknowledge.
- `de_addr` input 18: word address.
- `de_nbyte` input 4: active-low byte enables. Bit i maps to `de_w_data[8i+7:8i]`.
- `de_rnw` input 1: 1 = read, 0 = write.
- `de_w_data` input 32: write data.
- `de_r_data` output 32: read data, valid in the `de_ack` cycle of a read.
- `mem_cs` output 1: SRAM cycle strobe, one cycle per access.
- `mem_we` output 1: SRAM write, qualified by `mem_cs`.
- `mem_addr` output 18: SRAM word address.
- `mem_nbe` output 4: SRAM active-low byte enables.
- `mem_wdata` output 32: SRAM write data.
- `mem_rdata` input 32: SRAM read data, valid `WAIT_STATES`+1 cycles after the `mem_cs` cycle.
- `idle` output 1: high when no buffered write exists and no SRAM access is in flight.

## Operation
- State machine states: IDLE, WR_BUSY, RD_ISSUE, RD_WAIT, RD_ACK.
- Write buffer: valid flag plus address, byte-enable and data registers.
- **Write acceptance**
  - Condition: IDLE, `de_req`=1, `de_rnw`=0, `de_ack`=0 in the current cycle, buffer empty.
  - Action: the buffer captures address, byte enables and data; `de_ack` is high next cycle.
- **Write drain**
  - In the cycle after capture, `mem_cs`=`mem_we`=1 with the buffer contents.
  - The state then holds WR_BUSY for `WAIT_STATES` cycles; the buffer frees at the end of the last of these.
  - If `WAIT_STATES`=0, the buffer frees at the end of the strobe cycle.
- **Write with `de_nbyte`=4'b1111**
  - Acked on the normal schedule.
  - No SRAM cycle is issued and the buffer is never marked valid.
- **Read acceptance**
  - Condition: IDLE, `de_req`=1, `de_rnw`=1, `de_ack`=0, buffer empty and not WR_BUSY.
  - If a write is pending, the read waits until the drain completes. This gives read-after-write ordering by construction.
- **Read sequence**
  - RD_ISSUE: `mem_cs`=1, `mem_we`=0, `mem_nbe`=4'b0000; `de_nbyte` is ignored on reads.
  - RD_WAIT: lasts `WAIT_STATES`+1 cycles. `mem_rdata` is registered at the end of the last one.
  - RD_ACK: `de_ack`=1 and `de_r_data` is driven from the register; then return to IDLE.
- `de_r_data` holds its last read value until the next read completes.
- `de_req` is never sampled in a cycle where `de_ack`=1. This prevents double acceptance of a held request.
- Only one access is in flight on the SRAM side; no `mem_cs` strobe is issued while WR_BUSY or RD_WAIT.
- `mem_addr`, `mem_nbe` and `mem_wdata` may hold stale values when `mem_cs`=0. `mem_nbe`=4'b1111 when idle.

## Timing
- Cycle 0 is the first cycle in which an acceptable `de_req` is high.
- Write, buffer empty:
  - `de_ack` in cycle 1.
  - `mem_cs` in cycle 1.
  - Buffer free from cycle 2+`WAIT_STATES`.
- Read, no pending write:
  - `mem_cs` in cycle 1.
  - `mem_rdata` sampled at the end of cycle 2+`WAIT_STATES`.
  - `de_ack` and `de_r_data` in cycle 3+`WAIT_STATES`, which is cycle 4 at the default.
- Read behind a pending write: delayed by the remaining drain cycles, then timed as above.
- Reset values, applied asynchronously on `rst_n` low:
  - `de_ack`=0, `de_r_data`=0, `mem_cs`=0, `mem_we`=0, `mem_addr`=0, `mem_nbe`=4'b1111, `mem_wdata`=0, `idle`=1.
  - State is IDLE and the buffer is empty.
- Reset mid-operation:
  - A pending write is discarded and an in-flight read is abandoned.
  - No `de_ack` is issued for either.
  - `mem_cs` falls immediately.
- `de_req` rising in the same cycle as a drain's last busy cycle is accepted on the next edge; there is no lost or duplicated acknowledge.
- `idle` is combinational from state and buffer flag. It is low from cycle 1 of any accepted request with a memory access until the access retires.

## Test plan
- **Single write, `WAIT_STATES`=1:** addr 18'h00123, nbyte 4'b0000, data 32'hDEADBEEF.
  - Expect `de_ack` in cycle 1 and `mem_cs`/`mem_we` in cycle 1 with the same fields.
  - Expect `idle`=1 again from cycle 3.
- **Byte-masked write then read of the same address:**
  - Memory is preloaded with 32'h11111111; write nbyte 4'b1010 with data 32'hAABBCCDD.
  - The following read returns 32'h11BB11DD.
  - The read's `mem_cs` does not occur before the write's drain completes.
- **Back-to-back writes:** `de_req` is held and re-raised immediately after each ack.
  - Exactly one `de_ack` per request.
  - No `mem_cs` strobes closer than `WAIT_STATES`+1 cycles apart.
- **Null write:** nbyte 4'b1111.
  - `de_ack` in cycle 1, no `mem_cs`, `idle` stays 1.
- **Read latency sweep, `WAIT_STATES`=0, 1 and 3:**
  - `de_ack` lands in cycles 3, 4 and 6 respectively.
  - `de_r_data` matches the model data.
- **Reset mid-read:** assert `rst_n` low in the RD_WAIT cycle.
  - All outputs go to their reset values immediately and no `de_ack` appears.
  - A new read after reset completes normally.

Source files
------------

// File: rtl/de_mem_responder.sv
// Drawing-engine memory responder: posted single-entry write buffer,
// blocking reads, one SRAM access in flight at a time.
module de_mem_responder #(
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        de_req,
  output logic        de_ack,
  input  logic [17:0] de_addr,
  input  logic [3:0]  de_nbyte,
  input  logic        de_rnw,
  input  logic [31:0] de_w_data,
  output logic [31:0] de_r_data,
  output logic        mem_cs,
  output logic        mem_we,
  output logic [17:0] mem_addr,
  output logic [3:0]  mem_nbe,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        idle
);

  localparam logic [2:0] WS = 3'(WAIT_STATES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_BUSY,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_RD_ACK
  } state_e;

  state_e      st_q, st_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        wb_v_q, wb_v_d;
  logic [17:0] addr_q, addr_d;
  logic [3:0]  nbe_q, nbe_d;
  logic [31:0] data_q, data_d;
  logic        cs_q, cs_d;
  logic        we_q, we_d;
  logic        ack_q, ack_d;
  logic [31:0] rdata_q, rdata_d;

  logic accept;
  logic null_wr;

  // A held request is never re-sampled while its ack is showing.
  assign accept  = de_req & ~ack_q & ~wb_v_q;
  assign null_wr = (de_nbyte == 4'hF);

  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    wb_v_d  = wb_v_q;
    addr_d  = addr_q;
    nbe_d   = 4'hF;
    data_d  = data_q;
    cs_d    = 1'b0;
    we_d    = 1'b0;
    ack_d   = 1'b0;
    rdata_d = rdata_q;
    unique case (st_q)
      S_IDLE: begin
        if (accept && !de_rnw) begin
          ack_d = 1'b1;
          if (!null_wr) begin
            wb_v_d = 1'b1;
            addr_d = de_addr;
            nbe_d  = de_nbyte;
            data_d = de_w_data;
            cs_d   = 1'b1;
            we_d   = 1'b1;
            cnt_d  = WS;
            st_d   = S_WR_BUSY;
          end
        end else if (accept && de_rnw) begin
          addr_d = de_addr;
          nbe_d  = 4'h0;
          cs_d   = 1'b1;
          st_d   = S_RD_ISSUE;
        end
      end
      S_WR_BUSY: begin
        if (cnt_q == 3'd0) begin
          wb_v_d = 1'b0;
          st_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_RD_ISSUE: begin
        cnt_d = WS;
        st_d  = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (cnt_q == 3'd0) begin
          rdata_d = mem_rdata;
          ack_d   = 1'b1;
          st_d    = S_RD_ACK;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_RD_ACK: begin
        st_d = S_IDLE;
      end
      default: begin
        st_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= S_IDLE;
      cnt_q   <= '0;
      wb_v_q  <= 1'b0;
      addr_q  <= '0;
      nbe_q   <= 4'hF;
      data_q  <= '0;
      cs_q    <= 1'b0;
      we_q    <= 1'b0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      wb_v_q  <= wb_v_d;
      addr_q  <= addr_d;
      nbe_q   <= nbe_d;
      data_q  <= data_d;
      cs_q    <= cs_d;
      we_q    <= we_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
    end
  end

  assign de_ack    = ack_q;
  assign de_r_data = rdata_q;
  assign mem_cs    = cs_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_nbe   = nbe_q;
  assign mem_wdata = data_q;
  assign idle      = (st_q == S_IDLE) & ~wb_v_q;

endmodule

// File: tb/tb_de_mem_responder.sv
// Bench for de_mem_responder: three instances (WAIT_STATES 1, 0, 3),
// behavioural SRAM, queue scoreboard and cycle-level reference model.
module tb_de_mem_responder;

  typedef struct {
    int          cyc;
    logic        rd;
    logic [31:0] data;
  } ack_t;

  typedef struct {
    int          cyc;
    logic        we;
    logic [17:0] addr;
    logic [3:0]  nbe;
    logic [31:0] wdata;
  } cs_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   total;
  int   bad;

  logic [2:0]  de_req;
  logic [2:0]  de_ack;
  logic [17:0] de_addr   [3];
  logic [3:0]  de_nbyte  [3];
  logic [2:0]  de_rnw;
  logic [31:0] de_w_data [3];
  logic [31:0] de_r_data [3];
  logic [2:0]  mem_cs;
  logic [2:0]  mem_we;
  logic [17:0] mem_addr  [3];
  logic [3:0]  mem_nbe   [3];
  logic [31:0] mem_wdata [3];
  logic [31:0] mem_rdata [3];
  logic [2:0]  idle;

  ack_t ack_q [3][$];
  cs_t  cs_q  [3][$];

  logic [31:0] ref_mem [3][1024];
  int free_c [3];
  int w_lo [3];
  int w_hi [3];
  int p_lo [3];
  int p_hi [3];

  function automatic int ws_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 0 : 3);
  endfunction

  function automatic void chk(input string nm, input int k,
                              input logic [31:0] act,
                              input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst=%0d cyc=%0d got=%h want=%h",
               nm, k, cyc, act, exp);
    end
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int W = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
    logic [31:0] mem [1024];
    int          rv_cyc;
    logic [31:0] rv_data;

    initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'h11111111;
      rv_cyc  = -1;
      rv_data = '0;
    end

    always @(posedge clk) begin
      if (mem_cs[g]) begin
        if (mem_we[g]) begin
          for (int b = 0; b < 4; b++)
            if (!mem_nbe[g][b])
              mem[mem_addr[g][9:0]][8*b+:8] <= mem_wdata[g][8*b+:8];
        end else begin
          rv_data <= mem[mem_addr[g][9:0]];
          rv_cyc  <= cyc + W + 1;
        end
      end
    end

    assign mem_rdata[g] = (cyc == rv_cyc) ? rv_data : 32'hBAD0BAD0;

    de_mem_responder #(.WAIT_STATES(W)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .de_req    (de_req[g]),
      .de_ack    (de_ack[g]),
      .de_addr   (de_addr[g]),
      .de_nbyte  (de_nbyte[g]),
      .de_rnw    (de_rnw[g]),
      .de_w_data (de_w_data[g]),
      .de_r_data (de_r_data[g]),
      .mem_cs    (mem_cs[g]),
      .mem_we    (mem_we[g]),
      .mem_addr  (mem_addr[g]),
      .mem_nbe   (mem_nbe[g]),
      .mem_wdata (mem_wdata[g]),
      .mem_rdata (mem_rdata[g]),
      .idle      (idle[g])
    );
  end

  // Monitor: pops expectations whenever the DUT shows an ack or strobe.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 3; k++) begin
        ack_t e;
        cs_t  c;
        logic busy;
        if (de_ack[k]) begin
          if (ack_q[k].size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_ack inst=%0d cyc=%0d", k, cyc);
          end else begin
            e = ack_q[k].pop_front();
            chk("ack_cycle", k, cyc, e.cyc);
            if (e.rd) chk("r_data", k, de_r_data[k], e.data);
          end
        end
        if (mem_cs[k]) begin
          if (cs_q[k].size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_cs inst=%0d cyc=%0d", k, cyc);
          end else begin
            c = cs_q[k].pop_front();
            chk("cs_cycle", k, cyc, c.cyc);
            chk("cs_we", k, 32'(mem_we[k]), 32'(c.we));
            chk("cs_addr", k, 32'(mem_addr[k]), 32'(c.addr));
            chk("cs_nbe", k, 32'(mem_nbe[k]), 32'(c.nbe));
            if (c.we) chk("cs_wdata", k, mem_wdata[k], c.wdata);
          end
        end
        busy = (cyc >= w_lo[k] && cyc <= w_hi[k]) ||
               (cyc >= p_lo[k] && cyc <= p_hi[k]);
        chk("idle", k, 32'(idle[k]), 32'(!busy));
      end
    end
  end

  task automatic clear_model();
    for (int k = 0; k < 3; k++) begin
      free_c[k] = 0;
      w_lo[k] = 1; w_hi[k] = 0;
      p_lo[k] = 1; p_hi[k] = 0;
      ack_q[k].delete();
      cs_q[k].delete();
    end
  endtask

  task automatic set_window(input int k, input int lo, input int hi);
    p_lo[k] = w_lo[k];
    p_hi[k] = w_hi[k];
    w_lo[k] = lo;
    w_hi[k] = hi;
  endtask

  task automatic chk_reset(input string nm);
    for (int k = 0; k < 3; k++) begin
      chk({nm, "_ack"}, k, 32'(de_ack[k]), 32'd0);
      chk({nm, "_rdata"}, k, de_r_data[k], 32'd0);
      chk({nm, "_cs"}, k, 32'(mem_cs[k]), 32'd0);
      chk({nm, "_we"}, k, 32'(mem_we[k]), 32'd0);
      chk({nm, "_addr"}, k, 32'(mem_addr[k]), 32'd0);
      chk({nm, "_nbe"}, k, 32'(mem_nbe[k]), 32'hF);
      chk({nm, "_wdata"}, k, mem_wdata[k], 32'd0);
      chk({nm, "_idle"}, k, 32'(idle[k]), 32'd1);
    end
  endtask

  // Entered and left #1 after a rising edge.
  task automatic issue(input int k, input logic rnw,
                       input logic [17:0] addr, input logic [3:0] nb,
                       input logic [31:0] wd);
    int   w, r, a, n;
    ack_t e;
    cs_t  c;
    w = ws_of(k);
    r = cyc;
    a = (r > free_c[k]) ? r : free_c[k];
    if (rnw) begin
      e = '{a + 3 + w, 1'b1, ref_mem[k][addr[9:0]]};
      c = '{a + 1, 1'b0, addr, 4'h0, 32'h0};
      cs_q[k].push_back(c);
      free_c[k] = a + 4 + w;
      set_window(k, a + 1, a + 3 + w);
    end else begin
      e = '{a + 1, 1'b0, 32'h0};
      if (nb != 4'hF) begin
        c = '{a + 1, 1'b1, addr, nb, wd};
        cs_q[k].push_back(c);
        free_c[k] = a + 2 + w;
        set_window(k, a + 1, a + 1 + w);
        for (int b = 0; b < 4; b++)
          if (!nb[b]) ref_mem[k][addr[9:0]][8*b+:8] = wd[8*b+:8];
      end else begin
        free_c[k] = a + 2;
      end
    end
    ack_q[k].push_back(e);
    de_rnw[k]    = rnw;
    de_addr[k]   = addr;
    de_nbyte[k]  = nb;
    de_w_data[k] = wd;
    de_req[k]    = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!de_ack[k] && n < 60);
    if (!de_ack[k]) begin
      total++;
      bad++;
      $display("FAIL ack_timeout inst=%0d cyc=%0d", k, cyc);
      ack_q[k].delete();
      cs_q[k].delete();
    end
    @(posedge clk);
    #1;
    de_req[k] = 1'b0;
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int r;
    logic [17:0] a;
    cs_t c;
    cyc   = 0;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    de_req = '0;
    de_rnw = '0;
    for (int k = 0; k < 3; k++) begin
      de_addr[k] = '0;
      de_nbyte[k] = 4'hF;
      de_w_data[k] = '0;
      for (int i = 0; i < 1024; i++) ref_mem[k][i] = 32'h11111111;
    end
    clear_model();
    gap(3);
    chk_reset("rst_init");
    rst_n = 1'b1;
    gap(2);

    issue(0, 1'b0, 18'h00123, 4'h0, 32'hDEADBEEF);
    gap(3);
    issue(0, 1'b0, 18'h00045, 4'b1010, 32'hAABBCCDD);
    issue(0, 1'b1, 18'h00045, 4'h0, 32'h0);
    gap(2);
    for (int i = 0; i < 4; i++)
      issue(0, 1'b0, {8'h3C, 10'(i)}, 4'h0, $urandom);
    issue(0, 1'b1, 18'h00123, 4'h5, 32'h0);
    gap(2);
    issue(0, 1'b0, 18'h00007, 4'hF, 32'h55667788);
    gap(1);
    issue(0, 1'b1, 18'h00007, 4'h0, 32'h0);

    for (int k = 0; k < 3; k++) begin
      gap(2);
      issue(k, 1'b0, 18'h20010, 4'h0, $urandom);
      issue(k, 1'b1, 18'h20010, 4'h0, 32'h0);
      gap(1);
      issue(k, 1'b1, 18'h00123, 4'h0, 32'h0);
    end

    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < 25; n++) begin
        a = {8'($urandom), 10'($urandom_range(0, 15))};
        issue(k, 1'($urandom_range(0, 1)), a,
              ($urandom_range(0, 5) == 0) ? 4'hF : 4'($urandom),
              $urandom);
        gap($urandom_range(0, 2));
      end
    end

    gap(6);
    r = cyc;
    c = '{r + 1, 1'b0, 18'h00045, 4'h0, 32'h0};
    cs_q[0].push_back(c);
    set_window(0, r + 1, r + 4);
    de_rnw[0]  = 1'b1;
    de_addr[0] = 18'h00045;
    de_req[0]  = 1'b1;
    gap(2);
    rst_n     = 1'b0;
    de_req[0] = 1'b0;
    #1;
    chk_reset("rst_mid");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_hold_ack", 0, 32'(de_ack[0]), 32'd0);
    end
    chk("rst_cs_popped", 0, 32'(cs_q[0].size()), 32'd0);
    @(posedge clk);
    #1;
    clear_model();
    rst_n = 1'b1;
    gap(2);
    issue(0, 1'b1, 18'h00045, 4'h0, 32'h0);
    issue(0, 1'b0, 18'h00046, 4'b0011, 32'hCAFEF00D);
    issue(0, 1'b1, 18'h00046, 4'h0, 32'h0);
    gap(8);

    for (int k = 0; k < 3; k++) begin
      chk("ack_q_empty", k, 32'(ack_q[k].size()), 32'd0);
      chk("cs_q_empty", k, 32'(cs_q[k].size()), 32'd0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
